// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-port word
// memory. Each accepted transaction is carried through an optional
// wait-state phase, a single memory access cycle and a single response
// cycle before the next one can be accepted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction in flight; one requester may be accepted
// WAIT_ST | counting down the extra wait cycles before the access
// ACCESS  | memory is driven; store strobe or load data capture
// RESP    | one-cycle completion pulse to the owning requester
module mem_arbiter #(
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, WAIT_ST, ACCESS, RESP} state_t;

  // Counter load value; unused when there are no wait cycles.
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        last_grant;
  logic        grant_id;
  logic        accept;
  logic        lat_write;
  logic        lat_id;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Arbitration: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    accept     = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // Next-state and wait counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT > 0) begin
            state_nxt = WAIT_ST;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAIT_ST: begin
        if (cnt == 4'd0) begin
          state_nxt = ACCESS;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, grant history and the latched transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      lat_write  <= 1'b0;
      lat_id     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_write  <= grant_id ? req1_write : req0_write;
        lat_addr   <= grant_id ? req1_addr  : req0_addr;
        lat_wdata  <= grant_id ? req1_wdata : req0_wdata;
      end
    end
  end

  // Load data capture; each requester keeps its last load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_rdata <= 32'd0;
      rsp1_rdata <= 32'd0;
    end else if (state == ACCESS && !lat_write) begin
      if (lat_id) begin
        rsp1_rdata <= mem_read_data;
      end else begin
        rsp0_rdata <= mem_read_data;
      end
    end
  end

  // Memory and response outputs decoded from the state and latched fields.
  always_comb begin
    mem_address    = lat_addr;
    mem_write_data = lat_wdata;
    mem_write      = (state == ACCESS) && lat_write;
    rsp0_valid     = (state == RESP) && !lat_id;
    rsp1_valid     = (state == RESP) && lat_id;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT = 0, 3, 5) each with their own
// word memory, directed sequences, a transaction table and a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [N];
  logic        q0_valid [N];
  logic        q0_write [N];
  logic [31:0] q0_addr  [N];
  logic [31:0] q0_wdata [N];
  logic        q1_valid [N];
  logic        q1_write [N];
  logic [31:0] q1_addr  [N];
  logic [31:0] q1_wdata [N];
  logic        q0_ready [N];
  logic        q1_ready [N];
  logic        p0_valid [N];
  logic        p1_valid [N];
  logic [31:0] p0_rdata [N];
  logic [31:0] p1_rdata [N];
  logic        mwr      [N];
  logic [31:0] maddr    [N];
  logic [31:0] mwdata   [N];
  logic [31:0] mrdata   [N];

  logic [31:0] mem     [N][256];
  logic [31:0] ref_mem [N][256];
  int          wcnt    [N];

  logic        pl_en;
  int          pl_g;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int vectors = 0;
  int errs    = 0;

  function automatic int wait_of(input int g);
    if (g == 0) return 0;
    if (g == 1) return 3;
    return 5;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(.WAIT(g == 0 ? 0 : (g == 1 ? 3 : 5))) u_dut (
      .clk            (clk),
      .rst_n          (rst_n[g]),
      .req0_valid     (q0_valid[g]),
      .req0_write     (q0_write[g]),
      .req0_addr      (q0_addr[g]),
      .req0_wdata     (q0_wdata[g]),
      .req0_ready     (q0_ready[g]),
      .req1_valid     (q1_valid[g]),
      .req1_write     (q1_write[g]),
      .req1_addr      (q1_addr[g]),
      .req1_wdata     (q1_wdata[g]),
      .req1_ready     (q1_ready[g]),
      .rsp0_valid     (p0_valid[g]),
      .rsp0_rdata     (p0_rdata[g]),
      .rsp1_valid     (p1_valid[g]),
      .rsp1_rdata     (p1_rdata[g]),
      .mem_write      (mwr[g]),
      .mem_address    (maddr[g]),
      .mem_write_data (mwdata[g]),
      .mem_read_data  (mrdata[g])
    );
    assign mrdata[g] = mem[g][maddr[g][9:2]];
  end

  // Memory model: word-indexed, write on the rising edge, plus a preload port.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (mwr[g]) begin
        mem[g][maddr[g][9:2]] <= mwdata[g];
        wcnt[g] <= wcnt[g] + 1;
      end
    end
    if (pl_en) mem[pl_g][pl_idx] <= pl_data;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic set_req(input int g, input int id, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      q0_valid[g] = v; q0_write[g] = w; q0_addr[g] = a; q0_wdata[g] = d;
    end else begin
      q1_valid[g] = v; q1_write[g] = w; q1_addr[g] = a; q1_wdata[g] = d;
    end
  endtask

  function automatic logic get_ready(input int g, input int id);
    return (id == 0) ? q0_ready[g] : q1_ready[g];
  endfunction

  function automatic logic get_rsp(input int g, input int id);
    return (id == 0) ? p0_valid[g] : p1_valid[g];
  endfunction

  function automatic logic [31:0] get_rdata(input int g, input int id);
    return (id == 0) ? p0_rdata[g] : p1_rdata[g];
  endfunction

  task automatic preload(input int g, input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_g = g; pl_idx = idx; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[g][idx] = d;
  endtask

  task automatic chk_zero(input int g, input string tag);
    chk({tag, "_maddr"}, maddr[g], 32'd0);
    chk({tag, "_mwdata"}, mwdata[g], 32'd0);
    chk1({tag, "_mwr"}, mwr[g], 1'b0);
    chk1({tag, "_rsp0"}, p0_valid[g], 1'b0);
    chk1({tag, "_rsp1"}, p1_valid[g], 1'b0);
    chk({tag, "_rdata0"}, p0_rdata[g], 32'd0);
    chk({tag, "_rdata1"}, p1_rdata[g], 32'd0);
  endtask

  task automatic pulse_reset(input int g);
    @(negedge clk); rst_n[g] = 1'b0;
    @(negedge clk); rst_n[g] = 1'b1;
  endtask

  // One transaction from a single requester; reports timing relative to acceptance.
  task automatic do_txn(input int g, input int id, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int wr_at, output int nwr,
                        output logic [31:0] rdata, output logic [31:0] a1, output int other);
    bit got;
    got = 1'b0;
    @(negedge clk);
    set_req(g, id, 1'b1, w, a, d);
    for (int t = 0; t < 40; t++) begin
      #1;
      if (get_ready(g, id)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk1("accept_timeout", got, 1'b1);
    @(posedge clk);
    #1 set_req(g, id, 1'b0, ~w, ~a, ~d);
    lat = -1; wr_at = -1; nwr = 0; other = 0; rdata = '0; a1 = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) a1 = maddr[g];
      if (mwr[g]) begin
        nwr++;
        if (wr_at < 0) wr_at = k;
      end
      if (get_rsp(g, 1 - id)) other++;
      if (get_rsp(g, id)) begin
        lat = k;
        rdata = get_rdata(g, id);
      end
    end
  endtask

  // Randomized traffic against a transaction-level model: one transaction
  // owns the arbiter for WAIT+3 cycles from acceptance, ties alternate.
  task automatic run_random(input int g, input int ncyc);
    int          w_cyc;
    int          lg;
    int          busy_until;
    int          acc_cyc;
    int          win;
    bit          rid;
    bit          rwr;
    logic [31:0] racc_addr;
    logic [31:0] racc_wd;
    logic [31:0] rval;
    logic [31:0] exp_rd [2];
    bit          v [2];
    bit          w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    w_cyc = wait_of(g);
    lg = 1; busy_until = -1; acc_cyc = -100; rid = 0; rwr = 0;
    racc_addr = '0; racc_wd = '0; rval = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    v[0] = 0; v[1] = 0; w[0] = 0; w[1] = 0; a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    pulse_reset(g);
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || $urandom_range(7) == 0) begin
          v[i] = 1'($urandom_range(1));
          w[i] = 1'($urandom_range(1));
          a[i] = 32'h100 + 32'($urandom_range(7) << 2) + 32'($urandom_range(3));
          d[i] = $urandom;
        end
      end
      set_req(g, 0, v[0], w[0], a[0], d[0]);
      set_req(g, 1, v[1], w[1], a[1], d[1]);
      #1;
      win = -1;
      if (c > busy_until && (v[0] || v[1])) begin
        if (v[0] && v[1]) win = (lg == 1) ? 0 : 1;
        else win = v[0] ? 0 : 1;
      end
      if (c == acc_cyc + w_cyc + 2 && !rwr) exp_rd[rid] = rval;
      chk1("rnd_ready0", q0_ready[g], win == 0);
      chk1("rnd_ready1", q1_ready[g], win == 1);
      chk1("rnd_rsp0", p0_valid[g], c == acc_cyc + w_cyc + 2 && rid == 0);
      chk1("rnd_rsp1", p1_valid[g], c == acc_cyc + w_cyc + 2 && rid == 1);
      chk1("rnd_mem_write", mwr[g], c == acc_cyc + w_cyc + 1 && rwr);
      chk("rnd_rdata0", p0_rdata[g], exp_rd[0]);
      chk("rnd_rdata1", p1_rdata[g], exp_rd[1]);
      if (c > acc_cyc && c <= busy_until) begin
        chk("rnd_maddr", maddr[g], racc_addr);
        chk("rnd_mwdata", mwdata[g], racc_wd);
      end
      if (win >= 0) begin
        acc_cyc    = c;
        busy_until = c + w_cyc + 2;
        rid        = win[0];
        rwr        = w[win];
        racc_addr  = a[win];
        racc_wd    = d[win];
        rval       = ref_mem[g][a[win][9:2]];
        if (rwr) ref_mem[g][a[win][9:2]] = d[win];
        lg         = win;
        v[win]     = 0;
      end
      @(negedge clk);
    end
    set_req(g, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(g, 1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    int          exp_wr_at;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t        tbl [8];
    int          lat, wr_at, nwr, other, wsnap, bad, r0cnt, p0cnt, p1cnt;
    int          grants [$];
    logic [31:0] rdata, a1;

    // WAIT=3 instance: store/load mix, including unaligned low address bits.
    tbl[0] = '{1, 1'b1, 32'h20, 32'h12345678, 5, 4,  32'h00000000};
    tbl[1] = '{0, 1'b0, 32'h20, 32'h0,        5, -1, 32'h12345678};
    tbl[2] = '{0, 1'b1, 32'h23, 32'hA5A55A5A, 5, 4,  32'h12345678};
    tbl[3] = '{1, 1'b0, 32'h20, 32'h0,        5, -1, 32'hA5A55A5A};
    tbl[4] = '{1, 1'b0, 32'h26, 32'h0,        5, -1, 32'h55550000};
    tbl[5] = '{0, 1'b0, 32'h24, 32'h0,        5, -1, 32'h55550000};
    tbl[6] = '{1, 1'b1, 32'h24, 32'h0BADF00D, 5, 4,  32'h55550000};
    tbl[7] = '{0, 1'b0, 32'h27, 32'h0,        5, -1, 32'h0BADF00D};

    pl_en = 1'b0; pl_g = 0; pl_idx = '0; pl_data = '0;
    for (int g = 0; g < N; g++) begin
      rst_n[g] = 1'b0;
      set_req(g, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(g, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    #1;
    for (int g = 0; g < N; g++) begin
      chk_zero(g, "reset");
      chk1("reset_ready0", q0_ready[g], 1'b0);
      chk1("reset_ready1", q1_ready[g], 1'b0);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) rst_n[g] = 1'b1;

    for (int g = 0; g < N; g++)
      for (int k = 0; k < 8; k++) preload(g, 8'(64 + k), $urandom);
    preload(0, 8'd4, 32'hCAFEF00D);
    preload(0, 8'd5, 32'h0);
    preload(1, 8'd8, 32'h0);
    preload(1, 8'd9, 32'h55550000);
    preload(2, 8'd16, 32'h11111111);

    // WAIT=0 load from port 0.
    do_txn(0, 0, 1'b0, 32'h10, 32'h0, lat, wr_at, nwr, rdata, a1, other);
    chk("w0_lat", 32'(lat), 32'd2);
    chk("w0_addr_t1", a1, 32'h10);
    chk("w0_rdata", rdata, 32'hCAFEF00D);
    chk("w0_other_rsp", 32'(other), 32'd0);
    chk("w0_nwr", 32'(nwr), 32'd0);

    // Transaction table on WAIT=3.
    for (int i = 0; i < 8; i++) begin
      do_txn(1, tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, wr_at, nwr, rdata, a1, other);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_wr_at", i), 32'(wr_at), 32'(tbl[i].exp_wr_at));
      chk($sformatf("tbl%0d_nwr", i), 32'(nwr), tbl[i].wr ? 32'd1 : 32'd0);
      chk($sformatf("tbl%0d_addr", i), a1, tbl[i].addr);
      chk($sformatf("tbl%0d_other", i), 32'(other), 32'd0);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
    end

    // Port 0 pulses valid for one cycle while the arbiter sits in ACCESS.
    pulse_reset(1);
    wsnap = wcnt[1];
    set_req(1, 1, 1'b1, 1'b0, 32'h24, 32'h0);
    #1 chk1("drop_first_accept", q1_ready[1], 1'b1);
    @(posedge clk);
    #1 set_req(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    set_req(1, 0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
    #1 chk1("drop_ready0_in_access", q0_ready[1], 1'b0);
    @(negedge clk);
    set_req(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    r0cnt = 0; p0cnt = 0; p1cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (q0_ready[1]) r0cnt++;
      if (p0_valid[1]) p0cnt++;
      if (p1_valid[1]) p1cnt++;
      @(negedge clk);
    end
    chk("drop_ready0", 32'(r0cnt), 32'd0);
    chk("drop_rsp0", 32'(p0cnt), 32'd0);
    chk("drop_rsp1", 32'(p1cnt), 32'd1);
    chk("drop_rdata1", p1_rdata[1], 32'h0BADF00D);
    chk("drop_writes", 32'(wcnt[1] - wsnap), 32'd0);
    chk("drop_mem", mem[1][8], 32'hA5A55A5A);

    // Both ports valid from reset on WAIT=0: grants alternate 0,1,0,1.
    @(negedge clk);
    rst_n[0] = 1'b0;
    set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(0, 1, 1'b1, 1'b0, 32'h14, 32'h0);
    #1 chk_zero(0, "rr_reset");
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk1("rr_onehot", q0_ready[0] & q1_ready[0], 1'b0);
      chk1("rr_ready_slot", q0_ready[0] | q1_ready[0], (c % 3) == 0);
      if (q0_ready[0]) grants.push_back(0);
      if (q1_ready[0]) grants.push_back(1);
      @(negedge clk);
    end
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rr_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    repeat (3) @(negedge clk);

    // Reset during the wait phase of a store on WAIT=5 aborts it.
    do_txn(2, 1, 1'b0, 32'h40, 32'h0, lat, wr_at, nwr, rdata, a1, other);
    chk("w5_lat", 32'(lat), 32'd7);
    chk("w5_rdata", rdata, 32'h11111111);
    wsnap = wcnt[2];
    @(negedge clk);
    set_req(2, 0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    #1 chk1("abort_accept", q0_ready[2], 1'b1);
    @(posedge clk);
    #1 set_req(2, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("abort_maddr_wait", maddr[2], 32'h40);
    chk("abort_mwdata_wait", mwdata[2], 32'hDEADBEEF);
    chk1("abort_mwr_wait", mwr[2], 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1 chk_zero(2, "abort");
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (mwr[2] || p0_valid[2] || p1_valid[2]) bad++;
      @(negedge clk);
    end
    chk("abort_no_activity", 32'(bad), 32'd0);
    chk("abort_writes", 32'(wcnt[2] - wsnap), 32'd0);
    chk("abort_mem", mem[2][16], 32'h11111111);
    do_txn(2, 0, 1'b0, 32'h40, 32'h0, lat, wr_at, nwr, rdata, a1, other);
    chk("abort_reload", rdata, 32'h11111111);

    for (int g = 0; g < N; g++) run_random(g, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
